// File: rtl/conv1_ctrl.sv
// Frame sequencer for the conv1 stage: raster tracking of the pixel stream,
// window-valid generation, result tagging through the arithmetic latency, end-of-frame.
module conv1_ctrl #(
    parameter int WIDTH       = 28,
    parameter int HEIGHT      = 28,
    parameter int FILTER_SIZE = 5,
    parameter int CALC_LAT    = 1,
    localparam int CW         = $clog2(WIDTH),
    localparam int RW         = $clog2(HEIGHT),
    localparam int MW         = (CW > RW) ? CW : RW,
    localparam int CRD_W      = (MW > 5) ? MW : 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pixel_valid,
    output logic             busy,
    output logic             win_valid,
    output logic             res_valid,
    output logic [CRD_W-1:0] res_x,
    output logic [CRD_W-1:0] res_y,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic             win_q, win_d;
    logic [CRD_W-1:0] win_x_q, win_x_d, win_y_q, win_y_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             pix_acc_s, last_col_s, last_row_s, last_res_s, start_acc_s;

    assign pix_acc_s   = (state_q == S_RUN) && pixel_valid;
    assign start_acc_s = (state_q == S_IDLE) && start;
    assign last_col_s  = (col_q == CW'(WIDTH - 1));
    assign last_row_s  = (row_q == RW'(HEIGHT - 1));
    // The final window of the frame has left the delay line.
    assign last_res_s  = res_valid && (res_x == CRD_W'(WIDTH - FILTER_SIZE))
                                   && (res_y == CRD_W'(HEIGHT - FILTER_SIZE));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN; else state_d = S_IDLE;
            S_RUN:   if (pix_acc_s && last_col_s && last_row_s) state_d = S_FLUSH;
                     else state_d = S_RUN;
            S_FLUSH: if (last_res_s) state_d = S_DONE; else state_d = S_FLUSH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so busy/frame_done can be registered
    always_comb begin
        busy_d       = 1'b0;
        frame_done_d = 1'b0;
        case (state_d)
            S_RUN:   busy_d = 1'b1;
            S_FLUSH: busy_d = 1'b1;
            S_DONE:  frame_done_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    // Raster counters and window qualification
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (start_acc_s) begin
            col_d = {CW{1'b0}};
            row_d = {RW{1'b0}};
        end else if (pix_acc_s) begin
            if (last_col_s) begin
                col_d = {CW{1'b0}};
                if (last_row_s) begin
                    row_d = {RW{1'b0}};
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end else begin
            col_d = col_q;
        end
        win_d = pix_acc_s && (col_q >= CW'(FILTER_SIZE - 1)) && (row_q >= RW'(FILTER_SIZE - 1));
        if (win_d) begin
            win_x_d = CRD_W'(col_q) - CRD_W'(FILTER_SIZE - 1);
            win_y_d = CRD_W'(row_q) - CRD_W'(FILTER_SIZE - 1);
        end else begin
            win_x_d = win_x_q;
            win_y_d = win_y_q;
        end
    end

    // Counter, window and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= {CW{1'b0}};
            row_q        <= {RW{1'b0}};
            win_q        <= 1'b0;
            win_x_q      <= {CRD_W{1'b0}};
            win_y_q      <= {CRD_W{1'b0}};
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign win_valid  = win_q;

    // Tags only advance alongside a valid so the output coordinates hold between results.
    if (CALC_LAT == 0) begin : g_lat0
        assign res_valid = win_q;
        assign res_x     = win_x_q;
        assign res_y     = win_y_q;
    end else begin : g_latn
        logic [CALC_LAT-1:0]            dv_q;
        logic [CALC_LAT-1:0][CRD_W-1:0] dx_q;
        logic [CALC_LAT-1:0][CRD_W-1:0] dy_q;

        // Result delay line matching the arithmetic pipeline
        always_ff @(posedge clk) begin
            if (rst) begin
                dv_q <= {CALC_LAT{1'b0}};
                dx_q <= {(CALC_LAT*CRD_W){1'b0}};
                dy_q <= {(CALC_LAT*CRD_W){1'b0}};
            end else begin
                dv_q[0] <= win_q;
                if (win_q) begin
                    dx_q[0] <= win_x_q;
                    dy_q[0] <= win_y_q;
                end
                for (int i = 1; i < CALC_LAT; i++) begin
                    dv_q[i] <= dv_q[i-1];
                    if (dv_q[i-1]) begin
                        dx_q[i] <= dx_q[i-1];
                        dy_q[i] <= dy_q[i-1];
                    end
                end
            end
        end

        assign res_valid = dv_q[CALC_LAT-1];
        assign res_x     = dx_q[CALC_LAT-1];
        assign res_y     = dy_q[CALC_LAT-1];
    end

endmodule

// File: tb/tb_conv1_ctrl.sv
// Bench for conv1_ctrl: three builds (CALC_LAT 0, 1, 3) driven by the same randomized
// stream, checked every cycle against a pixel-index/schedule model of the frame rules.
module tb_conv1_ctrl;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int FS = 5;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst, start, pixel_valid;
    logic [2:0] busy_a, wv_a, rv_a, fd_a;
    logic [2:0][4:0] rx_a, ry_a;

    always #5 clk = ~clk;

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        conv1_ctrl #(.WIDTH(W), .HEIGHT(H), .FILTER_SIZE(FS),
                     .CALC_LAT((g == 0) ? 0 : ((g == 1) ? 1 : 3))) u_dut (
            .clk(clk), .rst(rst), .start(start), .pixel_valid(pixel_valid),
            .busy(busy_a[g]), .win_valid(wv_a[g]), .res_valid(rv_a[g]),
            .res_x(rx_a[g]), .res_y(ry_a[g]), .frame_done(fd_a[g]));
    end

    // ---------------- behavioural model (per lane) ----------------
    int cyc = 0;
    bit m_rst;
    bit run [3], inf [3];
    int npix [3], p117 [3];
    bit m_wv [3], m_rv [3], m_fd [3], m_busy [3];
    int m_rx [3], m_ry [3];
    bit sv [3][8];
    int sx [3][8], sy [3][8];

    always @(posedge clk) begin
        int c, r, slot;
        bit nfd;
        cyc++;
        m_rst = rst;
        for (int g = 0; g < 3; g++) begin
            if (rst) begin
                run[g] = 0; inf[g] = 0; npix[g] = 0;
                m_wv[g] = 0; m_rv[g] = 0; m_fd[g] = 0; m_busy[g] = 0;
                m_rx[g] = 0; m_ry[g] = 0;
                for (int s = 0; s < 8; s++) sv[g][s] = 0;
            end else begin
                nfd = inf[g] && !run[g] && m_rv[g] && m_rx[g] == W - FS && m_ry[g] == H - FS;
                m_wv[g] = 0;
                if (run[g] && pixel_valid) begin
                    c = npix[g] % W;
                    r = npix[g] / W;
                    npix[g]++;
                    if (npix[g] == 117) p117[g] = cyc - 1;
                    if (c >= FS - 1 && r >= FS - 1) begin
                        m_wv[g] = 1;
                        slot = (cyc + lat_of(g)) % 8;
                        sv[g][slot] = 1;
                        sx[g][slot] = c - (FS - 1);
                        sy[g][slot] = r - (FS - 1);
                    end
                    if (npix[g] == NPIX) run[g] = 0;
                end
                if (!inf[g] && !m_fd[g] && start) begin
                    inf[g] = 1; run[g] = 1; npix[g] = 0;
                end
                if (nfd) inf[g] = 0;
                m_fd[g] = nfd;
                m_busy[g] = inf[g];
                slot = cyc % 8;
                m_rv[g] = sv[g][slot];
                if (sv[g][slot]) begin
                    m_rx[g] = sx[g][slot];
                    m_ry[g] = sy[g][slot];
                    sv[g][slot] = 0;
                end
            end
        end
    end

    // ---------------- single compare process ----------------
    int total = 0, bad = 0, nprint = 0;
    int fcnt [3], lastc [3], lx [3], ly [3], fdn [3];
    bit zchk = 0, fin_req = 0;
    int tmo_cnt = 0, tmo_seen = 0;

    always @(negedge clk) begin
        #1;
        for (int g = 0; g < 3; g++) begin
            total++;
            if ({busy_a[g], wv_a[g], rv_a[g], fd_a[g]} !== {m_busy[g], m_wv[g], m_rv[g], m_fd[g]} ||
                rx_a[g] !== 5'(m_rx[g]) || ry_a[g] !== 5'(m_ry[g])) begin
                bad++;
                if (nprint < 30)
                    $display("FAIL cycle_cmp lat=%0d cyc=%0d got busy/win/res/done=%b%b%b%b x=%0d y=%0d want %b%b%b%b x=%0d y=%0d",
                             lat_of(g), cyc, busy_a[g], wv_a[g], rv_a[g], fd_a[g], rx_a[g], ry_a[g],
                             m_busy[g], m_wv[g], m_rv[g], m_fd[g], m_rx[g], m_ry[g]);
                nprint++;
            end
            if (m_rst) fcnt[g] = 0;
            if (rv_a[g] === 1'b1) begin
                if (fcnt[g] == 0) begin
                    total++;
                    if (rx_a[g] !== 5'd0 || ry_a[g] !== 5'd0 || cyc != p117[g] + 1 + lat_of(g)) begin
                        bad++;
                        $display("FAIL first_res lat=%0d got x=%0d y=%0d cyc=%0d want x=0 y=0 cyc=%0d",
                                 lat_of(g), rx_a[g], ry_a[g], cyc, p117[g] + 1 + lat_of(g));
                    end
                end
                fcnt[g]++;
                lastc[g] = cyc;
                lx[g] = int'(rx_a[g]);
                ly[g] = int'(ry_a[g]);
            end
            if (fd_a[g] === 1'b1) begin
                total++;
                if (fcnt[g] != 576 || lx[g] != 23 || ly[g] != 23 || cyc != lastc[g] + 1 || busy_a[g] !== 1'b0) begin
                    bad++;
                    $display("FAIL frame_end lat=%0d got count=%0d last=(%0d,%0d) gap=%0d busy=%b want count=576 last=(23,23) gap=1 busy=0",
                             lat_of(g), fcnt[g], lx[g], ly[g], cyc - lastc[g], busy_a[g]);
                end
                fcnt[g] = 0;
                fdn[g]++;
            end
            if (zchk) begin
                total++;
                if ({busy_a[g], wv_a[g], rv_a[g], fd_a[g]} !== 4'b0000 || rx_a[g] !== 5'd0 || ry_a[g] !== 5'd0) begin
                    bad++;
                    $display("FAIL reset_state lat=%0d got busy/win/res/done=%b%b%b%b x=%0d y=%0d want all 0",
                             lat_of(g), busy_a[g], wv_a[g], rv_a[g], fd_a[g], rx_a[g], ry_a[g]);
                end
            end
        end
        if (tmo_cnt != tmo_seen) begin
            total++;
            bad++;
            $display("FAIL frame_done_wait got no frame_done within 60 cycles want frame_done");
            tmo_seen = tmo_cnt;
        end
        if (fin_req) begin
            for (int g = 0; g < 3; g++) begin
                total++;
                if (fdn[g] != 3) begin
                    bad++;
                    $display("FAIL frame_count lat=%0d got %0d want 3", lat_of(g), fdn[g]);
                end
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit s, input bit p, input bit r);
        @(negedge clk);
        start = s;
        pixel_valid = p;
        rst = r;
    endtask

    // mode 0: continuous, 1: alternating, 2: random gaps + random starts
    task automatic feed(input int mode, input int abort_at);
        int n = 0;
        int k = 0;
        bit p, s;
        drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        while (n < NPIX) begin
            case (mode)
                0: p = 1'b1;
                1: p = (k % 2 == 0);
                default: p = ($urandom_range(0, 3) != 0);
            endcase
            s = (n == 300 && p) || (mode == 2 && $urandom_range(0, 63) == 0);
            if (abort_at >= 0 && n == abort_at && p) begin
                drive(s, 1'b1, 1'b1);
                return;
            end
            drive(s, p, 1'b0);
            if (p) n++;
            k++;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            if (fd_a[2] === 1'b1) return;
        end
        tmo_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pixel_valid = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        zchk = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        zchk = 1'b0;
        repeat (6) drive(1'b0, 1'b1, 1'b0);
        feed(0, -1);
        wait_done();
        feed(1, -1);
        wait_done();
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        feed(0, 400);
        drive(1'b0, 1'b0, 1'b0);
        zchk = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        zchk = 1'b0;
        repeat (5) drive(1'b0, 1'b1, 1'b0);
        feed(2, -1);
        wait_done();
        repeat (8) drive(1'b0, 1'b0, 1'b0);
        fin_req = 1'b1;
        repeat (5) drive(1'b0, 1'b0, 1'b0);
        $display("FAIL summary_not_reached");
        $fatal(1);
    end

endmodule

// File: doc/conv1_ctrl.md
Name: conv1_ctrl

Overview:
- Frame-level sequencer for the first convolution stage (5x5 kernel, 3 output channels, valid-only convolution).
- Tracks the raster position of an incoming pixel stream and decides when the 5x5 window held by the line buffer is a legal convolution position.
- Issues the window-valid strobe to the conv1 arithmetic, delays it by the arithmetic pipeline depth, and tags each result with its output coordinate.
- Signals end of frame once the last of the (WIDTH-4)x(HEIGHT-4) results has emerged.

Parameters:
- WIDTH, 28, input image width in pixels
- HEIGHT, 28, input image height in pixels
- FILTER_SIZE, 5, kernel edge length
- CALC_LAT, 1, number of register stages between window-valid issue and conv result availability (0..7)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; arms the controller for one frame
- pixel_valid  in  1  one pixel accepted into the line buffer this cycle
- busy  out  1  high from accepted start until frame_done
- win_valid  out  1  window currently presented to the conv arithmetic is a legal position
- res_valid  out  1  win_valid delayed by CALC_LAT cycles; qualifies conv_out_1..3
- res_x  out  5  output column of the result qualified by res_valid (0..WIDTH-FILTER_SIZE)
- res_y  out  5  output row of the result qualified by res_valid (0..HEIGHT-FILTER_SIZE)
- frame_done  out  1  one-cycle pulse after the last result of the frame

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. While rst=1, all state clears on the next edge.
- Reset values: state=IDLE; col=row=0; busy=0; win_valid=0; res_valid=0; res_x=res_y=0; frame_done=0; delay line cleared.
- IDLE state:
  - pixel_valid is ignored.
  - start=1 moves to RUN, with busy=1 on the next cycle and col=row=0.
- RUN state: on each pixel_valid:
  - col increments.
  - At col=WIDTH-1, col wraps to 0 and row increments.
- win_valid:
  - Registered with 1-cycle latency after the accepted pixel.
  - High iff that pixel had row>=FILTER_SIZE-1 and col>=FILTER_SIZE-1.
  - Low in every cycle without pixel_valid; gaps in pixel_valid only stall the counters.
- Result tag: the window coordinates (col-(FILTER_SIZE-1), row-(FILTER_SIZE-1)) travel through the CALC_LAT delay line together with win_valid.
  - CALC_LAT=0: res_valid=win_valid and res_x/res_y are the current window coordinates.
  - res_x/res_y hold their last value when res_valid=0.
- Last pixel: the pixel at col=WIDTH-1, row=HEIGHT-1 moves to FLUSH; row and col wrap to 0.
  - pixel_valid in FLUSH is ignored and does not count.
- FLUSH state: waits until the last result has left the delay line (res_valid with res_x=WIDTH-5, res_y=HEIGHT-5), then:
  - frame_done=1 for one cycle, in the cycle after that res_valid;
  - busy=0 in that same cycle;
  - return to IDLE.
- start while busy=1 is ignored, including in the frame_done cycle.
- A start in the first IDLE cycle after frame_done is accepted.
- Result count: exactly (WIDTH-FILTER_SIZE+1)*(HEIGHT-FILTER_SIZE+1) res_valid pulses per frame; 576 at default parameters.
- Reset mid-frame: everything returns to reset values at the next edge, with no frame_done and no further res_valid. Any in-flight delay-line entries are discarded.
- Coordinate widths: $clog2 of WIDTH/HEIGHT for the counters; the 5-bit port width suffices for defaults; widen if the parameters exceed 32.

Test Plan:
- Reset, then start, then 784 consecutive pixel_valid cycles (CALC_LAT=1) -> exactly 576 res_valid pulses.
  - First pulse has res_x=0, res_y=0, 2 cycles after the 117th pixel (row 4, col 4).
  - Last pulse has res_x=23, res_y=23.
  - frame_done one cycle after the last pulse; busy low in the same cycle.
- Same frame with pixel_valid toggled 1/0 every cycle -> identical sequence of (res_x, res_y) values; win_valid never high in a pixel_valid=0 cycle.
- pixel_valid pulses before start, and pulses after the 784th pixel during FLUSH -> no counter movement; still exactly 576 results.
- start pulsed mid-frame at pixel 300 -> ignored; the frame completes normally. A second start the cycle after frame_done -> a new frame begins at col=row=0.
- rst asserted at pixel 400 for one cycle -> all outputs 0 next cycle; no frame_done; a subsequent full frame yields 576 results.
- CALC_LAT=0 and CALC_LAT=3 builds -> res_valid occurs exactly CALC_LAT cycles after win_valid with matching coordinates; frame_done timing shifts accordingly.
